sum_datapath: RTL and testbench
===============================

// Module: sum_datapath
// PURPOSE
//   Register-file datapath driven by the sum-loop control FSM. It is the responder side of the
//   control interface: it decodes mux-select, write-enable, address and output-load strobes.
//   It executes register moves/adds, drives the iLe10 loop-condition status back to the FSM,
//   and holds a registered result with a valid strobe, a sticky overflow flag and a load counter.
// PARAMETERS
//   DATA_W  8   width of every register, ALU operand and outData
//   LIMIT   10  unsigned loop bound; iLe10 = (R1 <= LIMIT)
// PORTS
//   clk          in   1       single clock, all state updates on rising edge
//   reset        in   1       asynchronous, active-low reset (0 = reset asserted)
//   rfsrcmuxsel  in   1       write-data select: 0 = ALU sum, 1 = constant 1
//   rfwe         in   1       register-file write enable
//   waddr        in   2       write address (R0..R3)
//   raddr1       in   2       read port 1 address / ALU operand A / outData source
//   raddr2       in   2       read port 2 address / ALU operand B
//   outLoad      in   1       load outData from read port 1
//   iLe10        out  1       status to FSM: stored R1 <= LIMIT (unsigned)
//   outData      out  DATA_W  registered result
//   outValid     out  1       one-cycle strobe: outData just updated
//   overflow     out  1       sticky: an ALU write to the register file carried out
//   loadCount    out  8       number of outLoad events, wraps modulo 256
// BEHAVIOUR
//   - Reset (reset==0, async): R1..R3, outData, outValid, overflow, loadCount all 0.
//     Mid-operation reset clears state immediately; the first edge after release behaves
//     as from cold reset.
//   - Register file: 4 x DATA_W. R0 reads 0 always; writes to R0 are discarded (no flag effects).
//   - Reads are combinational from stored contents.
//     rdata1 = R[raddr1], rdata2 = R[raddr2].
//     No write-to-read bypass: a same-cycle read of the register being written returns the old value.
//   - ALU: {carry, sum} = rdata1 + rdata2 over DATA_W+1 bits; sum wraps mod 2^DATA_W.
//   - wdata = rfsrcmuxsel ? 1 : sum (constant zero-extended to DATA_W).
//   - Write: at rising edge, if rfwe && waddr!=0 then R[waddr] <= wdata. Latency 1 cycle.
//   - iLe10: combinational from stored R1 (value before any same-cycle write). After reset it is 1.
//   - overflow: set at edge when rfwe && waddr!=0 && !rfsrcmuxsel && carry.
//     It is held until reset and is never cleared by normal operation.
//   - Output: at edge, if outLoad then outData <= rdata1; otherwise outData holds.
//     outValid <= outLoad (registered), so outValid is high exactly in the cycle after each
//     outLoad cycle. Back-to-back outLoad keeps it high.
//     loadCount <= loadCount + 1 on each outLoad edge, wrapping 255 -> 0.
//   - outLoad and rfwe may be active in the same cycle.
//     outData takes the pre-write rdata1; the write proceeds independently.
//   - Unused address fields when rfwe=0/outLoad=0 have no effect. No internal FSM.
//     All sequencing is owned by the controller; the datapath is fully deterministic
//     per cycle from its inputs.
// TESTING
//   1 Reset: hold reset=0 with random inputs -> all outputs 0 except iLe10=1; release, idle inputs -> unchanged.
//   2 Full loop with controller sequence S0,S1,(S2,S3,S4,S5)*:
//     outValid pulses carry 0,1,3,...,45,55 (11 pulses), iLe10 falls when R1=11, final R2=66,
//     loadCount=11, overflow=0.
//   3 Write/read: rfsrcmuxsel=1 write R3 -> R3=1; waddr=0 rfwe=1 -> R0 still reads 0;
//     write R2 while raddr1=2 -> old value on ALU.
//   4 Overflow (DATA_W=8): R1=200, R2=100, add into R2 -> R2=44, overflow=1.
//     Later non-carry adds -> overflow stays 1.
//   5 Boundary: R1=LIMIT -> iLe10=1; R1=LIMIT+1 -> iLe10=0. outLoad 256 times -> loadCount=0.
//     outLoad 3 consecutive cycles -> outValid high 3 cycles.
//   6 Reset mid-loop: assert reset=0 asynchronously between edges during a write cycle
//     -> outputs clear without waiting for clk; no pending write lands after release.

Source files
------------

// File: rtl/sum_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : sum_datapath
//  Description : Register-file datapath for the sum-loop controller. Decodes
//                mux-select, write-enable, address and output-load strobes,
//                performs register moves/adds, reports R1 <= LIMIT back to the
//                controller, and holds a registered result with a valid
//                strobe, a sticky overflow flag and a load counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module sum_datapath #(
  parameter int DATA_W = 8,
  parameter int LIMIT  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rfsrcmuxsel,
  input  logic              rfwe,
  input  logic [1:0]        waddr,
  input  logic [1:0]        raddr1,
  input  logic [1:0]        raddr2,
  input  logic              outLoad,
  output logic              iLe10,
  output logic [DATA_W-1:0] outData,
  output logic              outValid,
  output logic              overflow,
  output logic [7:0]        loadCount
);

  localparam logic [DATA_W-1:0] C_LIMIT = DATA_W'(LIMIT);
  localparam logic [DATA_W-1:0] C_ONE   = DATA_W'(1);

  // R0 is hard-wired to zero, so only R1..R3 have storage
  logic [DATA_W-1:0] rf_q [1:3];
  logic [DATA_W-1:0] rf_d [1:3];

  logic [DATA_W-1:0] outdata_q,   outdata_d;
  logic              outvalid_q,  outvalid_d;
  logic              overflow_q,  overflow_d;
  logic [7:0]        loadcount_q, loadcount_d;

  logic [DATA_W-1:0] w_rdata1;
  logic [DATA_W-1:0] w_rdata2;
  logic [DATA_W:0]   w_alu_full;
  logic [DATA_W-1:0] w_sum;
  logic              w_carry;
  logic [DATA_W-1:0] w_wdata;
  logic              w_wr_en;

  // Combinational read ports straight from stored contents (no write bypass)
  always_comb begin
    w_rdata1 = '0;
    w_rdata2 = '0;
    case (raddr1)
      2'd1:    w_rdata1 = rf_q[1];
      2'd2:    w_rdata1 = rf_q[2];
      2'd3:    w_rdata1 = rf_q[3];
      default: w_rdata1 = '0;
    endcase
    case (raddr2)
      2'd1:    w_rdata2 = rf_q[1];
      2'd2:    w_rdata2 = rf_q[2];
      2'd3:    w_rdata2 = rf_q[3];
      default: w_rdata2 = '0;
    endcase
  end

  // ALU add with carry out, plus write-data select
  assign w_alu_full = {1'b0, w_rdata1} + {1'b0, w_rdata2};
  assign w_sum      = w_alu_full[DATA_W-1:0];
  assign w_carry    = w_alu_full[DATA_W];
  assign w_wdata    = rfsrcmuxsel ? C_ONE : w_sum;
  // Writes aimed at R0 are dropped entirely, including their flag effects
  assign w_wr_en    = rfwe && (waddr != 2'd0);

  // Loop-condition status uses the value stored before any same-cycle write
  assign iLe10 = (rf_q[1] <= C_LIMIT);

  // Next-state computation for register file and output registers
  always_comb begin
    for (int i = 1; i <= 3; i++) begin
      rf_d[i] = (w_wr_en && (waddr == 2'(i))) ? w_wdata : rf_q[i];
    end
    overflow_d  = overflow_q | (w_wr_en && !rfsrcmuxsel && w_carry);
    outdata_d   = outLoad ? w_rdata1 : outdata_q;
    outvalid_d  = outLoad;
    loadcount_d = outLoad ? (loadcount_q + 8'd1) : loadcount_q;
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i <= 3; i++) begin
        rf_q[i] <= '0;
      end
      outdata_q   <= '0;
      outvalid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      loadcount_q <= 8'd0;
    end else begin
      for (int i = 1; i <= 3; i++) begin
        rf_q[i] <= rf_d[i];
      end
      outdata_q   <= outdata_d;
      outvalid_q  <= outvalid_d;
      overflow_q  <= overflow_d;
      loadcount_q <= loadcount_d;
    end
  end

  assign outData   = outdata_q;
  assign outValid  = outvalid_q;
  assign overflow  = overflow_q;
  assign loadCount = loadcount_q;

endmodule
`default_nettype wire

// File: tb/tb_sum_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sum_datapath
//  Description : Self-checking bench for sum_datapath with a behavioural
//                register-file model and directed controller sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_datapath;

  localparam int DATA_W = 8;
  localparam int LIMIT  = 10;
  localparam int MOD    = 2 ** DATA_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              rfsrcmuxsel;
  logic              rfwe;
  logic [1:0]        waddr;
  logic [1:0]        raddr1;
  logic [1:0]        raddr2;
  logic              outLoad;
  logic              iLe10;
  logic [DATA_W-1:0] outData;
  logic              outValid;
  logic              overflow;
  logic [7:0]        loadCount;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state
  int m_r [4];
  int m_out, m_valid, m_ovf, m_cnt;

  sum_datapath #(.DATA_W(DATA_W), .LIMIT(LIMIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .rfsrcmuxsel(rfsrcmuxsel),
    .rfwe       (rfwe),
    .waddr      (waddr),
    .raddr1     (raddr1),
    .raddr2     (raddr2),
    .outLoad    (outLoad),
    .iLe10      (iLe10),
    .outData    (outData),
    .outValid   (outValid),
    .overflow   (overflow),
    .loadCount  (loadCount)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (got running, need finished)");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    m_out = 0; m_valid = 0; m_ovf = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    int a, b, s;
    a = m_r[raddr1];
    b = m_r[raddr2];
    s = a + b;
    if (rfwe && waddr != 2'd0) begin
      if (rfsrcmuxsel) m_r[waddr] = 1;
      else begin
        m_r[waddr] = s % MOD;
        if (s >= MOD) m_ovf = 1;
      end
    end
    if (outLoad) begin
      m_out = a;
      m_cnt = (m_cnt + 1) % 256;
    end
    m_valid = outLoad ? 1 : 0;
  endtask

  task automatic set_idle();
    rfsrcmuxsel = 1'b0; rfwe = 1'b0; waddr = 2'd0;
    raddr1 = 2'd0; raddr2 = 2'd0; outLoad = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b0;
    model_reset();
    tick();
    reset = 1'b1;
  endtask

  task automatic write_const(input int r);
    rfwe = 1'b1; rfsrcmuxsel = 1'b1; waddr = 2'(r);
    tick();
    set_idle();
  endtask

  task automatic add_into(input int d, input int a, input int b);
    rfwe = 1'b1; rfsrcmuxsel = 1'b0; waddr = 2'(d); raddr1 = 2'(a); raddr2 = 2'(b);
    tick();
    set_idle();
  endtask

  // builds value v (>=1) in register r by doubling; needs R3 == 1
  task automatic load_reg(input int r, input int v);
    int msb;
    msb = 0;
    for (int i = 0; i < 31; i++) if (((v >> i) & 1) == 1) msb = i;
    write_const(r);
    for (int bt = msb - 1; bt >= 0; bt--) begin
      add_into(r, r, r);
      if (((v >> bt) & 1) == 1) add_into(r, r, 3);
    end
  endtask

  task automatic read_reg(input int r, output int val);
    outLoad = 1'b1; raddr1 = 2'(r);
    tick();
    set_idle();
    val = int'(outData);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 5; c++) begin
      rfsrcmuxsel = 1'($urandom); rfwe = 1'($urandom); outLoad = 1'($urandom);
      waddr = 2'($urandom); raddr1 = 2'($urandom); raddr2 = 2'($urandom);
      tick();
    end
    n_tests++;
    if (outData !== 0 || outValid !== 0 || overflow !== 0 || loadCount !== 0 || iLe10 !== 1) begin
      n_fail++;
      $display("FAIL reset_hold: got data=%0d valid=%0b ovf=%0b cnt=%0d le=%0b, need 0 0 0 0 1",
               outData, outValid, overflow, loadCount, iLe10);
    end
    set_idle();
    reset = 1'b1;
    tick(); tick();
    n_tests++;
    if (outData !== 0 || outValid !== 0 || overflow !== 0 || loadCount !== 0 || iLe10 !== 1) begin
      n_fail++;
      $display("FAIL reset_release: got data=%0d valid=%0b ovf=%0b cnt=%0d le=%0b, need 0 0 0 0 1",
               outData, outValid, overflow, loadCount, iLe10);
    end
  endtask

  task automatic test_full_loop();
    int pulses, iter, v;
    bit done, cont;
    do_reset();
    write_const(1);   // R1 = 1
    write_const(3);   // R3 = 1 (increment)
    pulses = 0; iter = 0; done = 0;
    while (!done && iter < 20) begin
      outLoad = 1'b1; raddr1 = 2'd2;
      tick();
      set_idle();
      n_tests++;
      if (outValid !== 1'b1 || int'(outData) != pulses * (pulses + 1) / 2) begin
        n_fail++;
        $display("FAIL loop_pulse%0d: got valid=%0b data=%0d, need 1 %0d",
                 pulses, outValid, outData, pulses * (pulses + 1) / 2);
      end
      pulses++;
      add_into(2, 2, 1);
      n_tests++;
      if (outValid !== 1'b0) begin
        n_fail++;
        $display("FAIL loop_valid_drop: got %0b, need 0", outValid);
      end
      cont = iLe10;
      n_tests++;
      if (iLe10 !== ((iter + 1) <= LIMIT)) begin
        n_fail++;
        $display("FAIL loop_ile10 R1=%0d: got %0b, need %0b", iter + 1, iLe10, ((iter + 1) <= LIMIT));
      end
      add_into(1, 1, 3);
      tick();
      if (!cont) done = 1;
      iter++;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL loop_timeout: got no exit after %0d iterations, need exit", iter);
    end
    n_tests++;
    if (pulses != 11 || loadCount !== 8'd11 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL loop_totals: got pulses=%0d cnt=%0d ovf=%0b, need 11 11 0", pulses, loadCount, overflow);
    end
    read_reg(2, v);
    n_tests++;
    if (v != 66) begin
      n_fail++;
      $display("FAIL loop_final_R2: got %0d, need 66", v);
    end
  endtask

  task automatic test_write_read();
    int v;
    do_reset();
    write_const(3);
    read_reg(3, v);
    n_tests++;
    if (v != 1) begin n_fail++; $display("FAIL wr_const_R3: got %0d, need 1", v); end
    write_const(0);
    read_reg(0, v);
    n_tests++;
    if (v != 0) begin n_fail++; $display("FAIL wr_R0: got %0d, need 0", v); end
    write_const(2);
    rfwe = 1'b1; rfsrcmuxsel = 1'b0; waddr = 2'd2; raddr1 = 2'd2; raddr2 = 2'd2; outLoad = 1'b1;
    tick();
    set_idle();
    n_tests++;
    if (outData !== 8'd1) begin n_fail++; $display("FAIL wr_no_bypass: got %0d, need 1", outData); end
    read_reg(2, v);
    n_tests++;
    if (v != 2) begin n_fail++; $display("FAIL wr_R2_after: got %0d, need 2", v); end
  endtask

  task automatic test_overflow();
    int v;
    do_reset();
    write_const(3);
    load_reg(1, 200);
    load_reg(2, 100);
    n_tests++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_preload: got %0b, need 0", overflow); end
    add_into(0, 1, 2);
    n_tests++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_R0_write: got %0b, need 0", overflow); end
    add_into(2, 1, 2);
    n_tests++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %0b, need 1", overflow); end
    read_reg(2, v);
    n_tests++;
    if (v != 44) begin n_fail++; $display("FAIL ovf_R2_wrap: got %0d, need 44", v); end
    add_into(1, 3, 3);
    read_reg(1, v);
    n_tests++;
    if (overflow !== 1'b1 || v != 2) begin
      n_fail++;
      $display("FAIL ovf_sticky: got ovf=%0b R1=%0d, need 1 2", overflow, v);
    end
  endtask

  task automatic test_boundary();
    int vcount;
    do_reset();
    write_const(3);
    load_reg(1, LIMIT);
    n_tests++;
    if (iLe10 !== 1'b1) begin n_fail++; $display("FAIL bnd_at_limit: got %0b, need 1", iLe10); end
    add_into(1, 1, 3);
    n_tests++;
    if (iLe10 !== 1'b0) begin n_fail++; $display("FAIL bnd_over_limit: got %0b, need 0", iLe10); end
    do_reset();
    vcount = 0;
    for (int c = 0; c < 256; c++) begin
      outLoad = 1'b1; raddr1 = 2'($urandom);
      tick();
      if (outValid === 1'b1) vcount++;
    end
    set_idle();
    n_tests++;
    if (loadCount !== 8'd0 || vcount != 256) begin
      n_fail++;
      $display("FAIL bnd_count_wrap: got cnt=%0d valid_cycles=%0d, need 0 256", loadCount, vcount);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      outLoad = 1'b1;
      tick();
      n_tests++;
      if (outValid !== 1'b1) begin n_fail++; $display("FAIL bnd_b2b_valid%0d: got %0b, need 1", c, outValid); end
    end
    set_idle();
    tick();
    n_tests++;
    if (outValid !== 1'b0 || loadCount !== 8'd3) begin
      n_fail++;
      $display("FAIL bnd_b2b_end: got valid=%0b cnt=%0d, need 0 3", outValid, loadCount);
    end
  endtask

  task automatic test_reset_mid();
    int v;
    do_reset();
    write_const(3);
    load_reg(1, 5);
    outLoad = 1'b1; raddr1 = 2'd1;
    tick();
    n_tests++;
    if (outData !== 8'd5 || outValid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_preload: got data=%0d valid=%0b, need 5 1", outData, outValid);
    end
    rfwe = 1'b1; rfsrcmuxsel = 1'b1; waddr = 2'd2; outLoad = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (outData !== 0 || outValid !== 0 || loadCount !== 0 || iLe10 !== 1) begin
      n_fail++;
      $display("FAIL mid_async_clear: got data=%0d valid=%0b cnt=%0d le=%0b, need 0 0 0 1",
               outData, outValid, loadCount, iLe10);
    end
    tick();
    set_idle();
    reset = 1'b1;
    tick();
    read_reg(2, v);
    n_tests++;
    if (v != 0) begin n_fail++; $display("FAIL mid_no_pending_write: got R2=%0d, need 0", v); end
    read_reg(1, v);
    n_tests++;
    if (v != 0 || loadCount !== 8'd2) begin
      n_fail++;
      $display("FAIL mid_cold_state: got R1=%0d cnt=%0d, need 0 2", v, loadCount);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rfsrcmuxsel = ($urandom_range(0, 3) == 0);
      rfwe = 1'($urandom); outLoad = 1'($urandom);
      waddr = 2'($urandom); raddr1 = 2'($urandom); raddr2 = 2'($urandom);
      tick();
      n_tests++;
      if (int'(outData) != m_out || int'(outValid) != m_valid || int'(overflow) != m_ovf ||
          int'(loadCount) != m_cnt || iLe10 !== (m_r[1] <= LIMIT)) begin
        n_fail++;
        $display("FAIL rand_cyc%0d: got data=%0d valid=%0b ovf=%0b cnt=%0d le=%0b, need %0d %0d %0d %0d %0b",
                 c, outData, outValid, overflow, loadCount, iLe10,
                 m_out, m_valid, m_ovf, m_cnt, (m_r[1] <= LIMIT));
      end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    reset = 1'b0;
    model_reset();
    test_reset();
    test_full_loop();
    test_write_read();
    test_overflow();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
